// File: rtl/rv32_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RV32I core: sequencer states,
// base opcodes and PC source encodings.
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] PCSEL_PLUS4  = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_JAL    = 2'd2;
    localparam logic [1:0] PCSEL_JALR   = 2'd3;

endpackage

// File: rtl/rv32_opclass.sv
// Combinational opcode-to-class decode, shared by the sequencer and the
// datapath decoder so both agree on which opcodes are legal.
module rv32_opclass
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_alu,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jal,
    output logic       is_jalr,
    output logic       is_legal
);

    always_comb begin
        is_alu    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM: is_alu = 1'b1;
            OPC_LOAD:   is_load   = 1'b1;
            OPC_STORE:  is_store  = 1'b1;
            OPC_BRANCH: is_branch = 1'b1;
            OPC_JAL:    is_jal    = 1'b1;
            OPC_JALR:   is_jalr   = 1'b1;
            default:    ;
        endcase
        is_legal = is_alu | is_load | is_store | is_branch | is_jal | is_jalr;
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Per-instruction IF/ID/EX/MEM/WB sequencer: issues the single-cycle write
// strobes, handles memory ready handshakes and counts retired instructions.
module multicycle_sequencer
    import rv32_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] num_inst
);

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   set_illegal;

    logic is_alu, is_load, is_store, is_branch, is_jal, is_jalr, is_legal;

    rv32_opclass u_opclass (
        .opcode    (opcode),
        .is_alu    (is_alu),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .is_legal  (is_legal)
    );

    // Reset aborts whatever instruction is in flight; strobes decode from IF.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IF;
            num_inst <= '0;
            illegal  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                num_inst <= num_inst + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    // Retirement always coincides with pc_write, so the counter keys off it.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = PCSEL_PLUS4;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            ST_IF: begin
                imem_req = !halt_req;
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_ID;
                end
            end
            ST_ID: begin
                if (is_jal || is_jalr) begin
                    state_d = ST_WB;
                end else if (is_legal) begin
                    state_d = ST_EX;
                end else begin
                    state_d     = ST_HALT;
                    set_illegal = 1'b1;
                end
            end
            ST_EX: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else if (is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken ? PCSEL_BRANCH : PCSEL_PLUS4;
                    state_d  = ST_IF;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        state_d  = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
                if (is_jal) begin
                    pc_sel = PCSEL_JAL;
                end else if (is_jalr) begin
                    pc_sel = PCSEL_JALR;
                end
                state_d = ST_IF;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
        retire = pc_write;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: table of instructions expanded
// into per-cycle expected steps on a scoreboard queue, plus corner sequences.
module tb_multicycle_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        halt_req;
    logic [2:0]  state;
    logic        imem_req, ir_write, pc_write, dmem_req, dmem_we, rf_we, halted, illegal;
    logic [1:0]  pc_sel;
    logic [31:0] num_inst;

    multicycle_sequencer #(.CNT_W(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .state        (state),
        .imem_req     (imem_req),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .halted       (halted),
        .illegal      (illegal),
        .num_inst     (num_inst)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] op;
        logic       taken;
        int         imemWaits;
        int         dmemWaits;
        int         expCycles;
    } vecT;

    // Strobe vector order: imem_req, ir_write, pc_write, pc_sel[1:0], dmem_req, dmem_we, rf_we, halted
    typedef struct {
        logic       ir;
        logic       dr;
        logic [2:0] st;
        logic [8:0] strobes;
    } stepT;

    stepT q[$];
    vecT  vecs[12];
    int   checks = 0;
    int   errors = 0;
    int   expCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushStep(input logic ir, input logic dr, input logic [2:0] st,
                            input logic imemReq, input logic irWrite, input logic pcWrite,
                            input logic [1:0] pcSel, input logic dmemReq, input logic dmemWe,
                            input logic rfWe, input logic hlt);
        stepT s;
        s.ir = ir;
        s.dr = dr;
        s.st = st;
        s.strobes = {imemReq, irWrite, pcWrite, pcSel, dmemReq, dmemWe, rfWe, hlt};
        q.push_back(s);
    endtask

    // Expected cycle-by-cycle trace of one instruction, written per opcode class.
    task automatic buildInstr(input logic [6:0] op, input logic taken, input int iw, input int dw);
        for (int i = 0; i < iw; i++) pushStep(0, 0, 3'd0, 1, 0, 0, 2'd0, 0, 0, 0, 0);
        pushStep(1, 0, 3'd0, 1, 1, 0, 2'd0, 0, 0, 0, 0);
        pushStep(0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                pushStep(0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0);
                pushStep(0, 0, 3'd4, 0, 0, 1, 2'd0, 0, 0, 1, 0);
            end
            7'b0000011: begin
                pushStep(0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0);
                for (int i = 0; i < dw; i++) pushStep(0, 0, 3'd3, 0, 0, 0, 2'd0, 1, 0, 0, 0);
                pushStep(0, 1, 3'd3, 0, 0, 0, 2'd0, 1, 0, 0, 0);
                pushStep(0, 0, 3'd4, 0, 0, 1, 2'd0, 0, 0, 1, 0);
            end
            7'b0100011: begin
                pushStep(0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0);
                for (int i = 0; i < dw; i++) pushStep(0, 0, 3'd3, 0, 0, 0, 2'd0, 1, 1, 0, 0);
                pushStep(0, 1, 3'd3, 0, 0, 1, 2'd0, 1, 1, 0, 0);
            end
            7'b1100011: pushStep(0, 0, 3'd2, 0, 0, 1, taken ? 2'd1 : 2'd0, 0, 0, 0, 0);
            7'b1101111: pushStep(0, 0, 3'd4, 0, 0, 1, 2'd2, 0, 0, 1, 0);
            7'b1100111: pushStep(0, 0, 3'd4, 0, 0, 1, 2'd3, 0, 0, 1, 0);
            default: for (int i = 0; i < 10; i++) pushStep(0, 0, 3'd5, 0, 0, 0, 2'd0, 0, 0, 0, 1);
        endcase
    endtask

    // Drains the scoreboard: each popped step drives inputs, then is compared at negedge.
    task automatic applyStimulus(input string tag, output int retireCyc);
        stepT s;
        int   cyc;
        cyc = 0;
        retireCyc = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            imem_ready = s.ir;
            dmem_ready = s.dr;
            @(negedge CLK);
            cyc++;
            checkOutput($sformatf("%s c%0d state", tag, cyc), 32'(state), 32'(s.st));
            checkOutput($sformatf("%s c%0d strobes", tag, cyc),
                        32'({imem_req, ir_write, pc_write, pc_sel, dmem_req, dmem_we, rf_we, halted}),
                        32'(s.strobes));
            if (pc_write && retireCyc == 0) retireCyc = cyc;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int retireCyc;

        vecs[0]  = '{7'b0110011, 1'b0, 0, 0, 4};
        vecs[1]  = '{7'b0000011, 1'b0, 0, 3, 8};
        vecs[2]  = '{7'b1100011, 1'b1, 0, 0, 3};
        vecs[3]  = '{7'b1100011, 1'b0, 0, 0, 3};
        vecs[4]  = '{7'b1100111, 1'b0, 0, 0, 3};
        vecs[5]  = '{7'b1101111, 1'b0, 0, 0, 3};
        vecs[6]  = '{7'b0010011, 1'b0, 2, 0, 6};
        vecs[7]  = '{7'b0110111, 1'b0, 0, 0, 4};
        vecs[8]  = '{7'b0010111, 1'b0, 0, 0, 4};
        vecs[9]  = '{7'b0100011, 1'b0, 0, 0, 4};
        vecs[10] = '{7'b0000011, 1'b0, 0, 0, 5};
        vecs[11] = '{7'b0100011, 1'b1, 1, 1, 6};

        RST = 1'b1;
        opcode = 7'b0110011;
        branch_taken = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        halt_req = 1'b0;
        @(negedge CLK);
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset num_inst", num_inst, 32'd0);
        checkOutput("reset illegal", 32'(illegal), 32'd0);
        checkOutput("reset ir_write", 32'(ir_write), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            branch_taken = vecs[i].taken;
            buildInstr(vecs[i].op, vecs[i].taken, vecs[i].imemWaits, vecs[i].dmemWaits);
            applyStimulus($sformatf("vec%0d", i), retireCyc);
            expCount++;
            checkOutput($sformatf("vec%0d latency", i), 32'(retireCyc), 32'(vecs[i].expCycles));
            checkOutput($sformatf("vec%0d num_inst", i), num_inst, 32'(expCount));
        end

        opcode = 7'b1111111;
        buildInstr(7'b1111111, 1'b0, 0, 0);
        applyStimulus("illegal", retireCyc);
        checkOutput("illegal flag", 32'(illegal), 32'd1);
        checkOutput("illegal num_inst", num_inst, 32'(expCount));
        checkOutput("illegal no retire", 32'(retireCyc), 32'd0);

        // Recover from HALT, then abort a STORE in MEM with an asynchronous reset.
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        opcode = 7'b0100011;
        pushStep(1, 0, 3'd0, 1, 1, 0, 2'd0, 0, 0, 0, 0);
        pushStep(0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        pushStep(0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        applyStimulus("store pre", retireCyc);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge CLK);
        checkOutput("store mem state", 32'(state), 32'd3);
        checkOutput("store mem dmem_we", 32'(dmem_we), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("abort state", 32'(state), 32'd0);
        checkOutput("abort num_inst", num_inst, 32'd0);
        checkOutput("abort dmem_we", 32'(dmem_we), 32'd0);
        checkOutput("abort dmem_req", 32'(dmem_req), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("post-abort c%0d state", i), 32'(state), 32'd0);
            checkOutput($sformatf("post-abort c%0d dmem_we", i), 32'(dmem_we), 32'd0);
        end

        // halt_req outranks imem_ready in IF.
        @(posedge CLK);
        #1;
        halt_req = 1'b1;
        imem_ready = 1'b1;
        @(negedge CLK);
        checkOutput("halt_req imem_req", 32'(imem_req), 32'd0);
        checkOutput("halt_req ir_write", 32'(ir_write), 32'd0);
        @(posedge CLK);
        #1;
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("halt c%0d state", i), 32'(state), 32'd5);
            checkOutput($sformatf("halt c%0d halted", i), 32'(halted), 32'd1);
            checkOutput($sformatf("halt c%0d illegal", i), 32'(illegal), 32'd0);
            checkOutput($sformatf("halt c%0d imem_req", i), 32'(imem_req), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Per-instruction state machine for the multi-cycle RV32I CPU. It sequences one instruction through the IF/ID/EX/MEM/WB steps.
- Issues the single-cycle write strobes: PC, IR, register file and data-memory write. Handles the instruction- and data-memory ready handshakes and counts retired instructions.
- Sits beside the opcode decoder. The decoder supplies static datapath selects; this block supplies *when* they take effect.

Parameters:
CNT_W, 32, width of the retired-instruction counter num_inst.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
opcode  input  7  opcode field of the latched instruction register
branch_taken  input  1  ALU branch-compare result, valid in EX
imem_ready  input  1  instruction memory has data this cycle
dmem_ready  input  1  data memory access completes this cycle
halt_req  input  1  request to stop before the next fetch
state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
imem_req  output  1  instruction fetch request
ir_write  output  1  load the instruction register
pc_write  output  1  update the PC this cycle
pc_sel  output  2  PC source: 0=PC+4, 1=branch target, 2=JAL target, 3=JALR target
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
rf_we  output  1  register file write strobe
halted  output  1  sequencer is in HALT
illegal  output  1  HALT was entered because of an unknown opcode
num_inst  output  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, while RST=1):
  - state=IF; num_inst=0; illegal=0.
  - All strobes are 0 because they decode from IF with imem_ready=0.
- Asserting RST mid-instruction aborts it immediately. No strobe from the aborted instruction may appear after RST rises.
- Output timing:
  - All outputs are combinational decodes of the registered state and the current inputs.
  - num_inst and illegal are registered.
  - Unlisted strobes are 0 in every state.
- IF:
  - imem_req = !halt_req.
  - halt_req=1 -> HALT next, with no request issued.
  - Otherwise, stay in IF until imem_ready=1. In that cycle ir_write=1, then go to ID.
- ID (always 1 cycle):
  - JAL (1101111) or JALR (1100111) -> WB.
  - LUI, AUIPC, R-type, I-type, LOAD, STORE, BRANCH -> EX.
  - Any other opcode -> HALT with illegal<=1.
- EX (1 cycle):
  - LUI/AUIPC/R-type/I-type -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: pc_write=1, pc_sel = branch_taken ? 1 : 0, num_inst+1, -> IF.
- MEM:
  - dmem_req=1 while waiting; dmem_we=1 for STORE.
  - Hold in MEM until dmem_ready=1.
  - LOAD -> WB.
  - STORE: pc_write=1, pc_sel=0 and num_inst+1 in the dmem_ready cycle, -> IF.
- WB (1 cycle):
  - rf_we=1 and pc_write=1, num_inst+1, -> IF.
  - pc_sel = 2 for JAL, 3 for JALR, else 0.
- HALT:
  - Terminal; halted=1; all strobes 0.
  - Exited only by RST.
- Opcode stability: opcode is stable from ID onward because the IR is written only in IF. The sequencer samples it in ID, EX, MEM and WB.
- Latency with zero-wait memories (imem_ready=dmem_ready=1):
  - R/I/LUI/AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - JAL/JALR: 3 cycles.
  - Each wait cycle at imem_ready or dmem_ready adds exactly 1.
- Counter:
  - num_inst increments exactly once per retired instruction, in the pc_write cycle.
  - Wraps modulo 2^CNT_W without a flag.
- Simultaneous events:
  - halt_req is honoured only in IF.
  - An instruction past IF always completes before halt_req takes effect.
  - halt_req has priority over imem_ready in the same IF cycle.

Decomposition:
- Shared package rv32_ctrl_pkg holds:
  - state encoding constants (IF..HALT);
  - the nine opcode constants;
  - pc_sel encodings.
- Natural sub-module: rv32_opclass. It is a combinational opcode-to-class decoder with outputs is_alu, is_load, is_store, is_branch, is_jal, is_jalr, is_legal, shared with the datapath decoder.
- The counter stays inline.

Test Plan:
- R-type 0110011, both readies tied 1:
  - state sequence IF,ID,EX,WB, then IF.
  - rf_we and pc_write high only in WB with pc_sel=0.
  - num_inst 0->1.
- LOAD 0000011 with dmem_ready low for 3 cycles:
  - MEM lasts 4 cycles with dmem_req=1, dmem_we=0.
  - Then WB with rf_we=1.
  - Total 8 cycles.
- BRANCH, branch_taken=1 then a second BRANCH with branch_taken=0:
  - EX shows pc_write=1 with pc_sel=1, then pc_sel=0.
  - rf_we never asserts.
  - num_inst +2.
- JALR 1100111 then JAL 1101111:
  - IF,ID,WB each.
  - WB pc_sel=3, then 2.
  - rf_we=1 in both WB cycles.
- Opcode 1111111:
  - after ID, state=HALT, halted=1, illegal=1.
  - All strobes 0 for 10 further cycles.
  - num_inst unchanged.
- RST pulsed during MEM of a STORE; and halt_req=1 in IF:
  - reset gives state=IF, num_inst=0, no dmem_we afterwards.
  - halt_req gives HALT with imem_req never asserted and illegal=0.
